// File: rtl/spi_slave_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx_if
// Description : Control, serial-line and RX FIFO host signals of spi_slave_rx.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_rx_if;
  logic        enable;
  logic [4:0]  word_size;
  logic [1:0]  mode;
  logic        spi_clk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        rd_pop;
  logic        clear_ov;
  logic [31:0] rd_data;
  logic        rx_empty;
  logic        rx_full;
  logic [6:0]  rx_level;
  logic        rx_ov;
  logic        frame_err;

  // master: host/controller side that drives the receiver
  modport master (
    output enable, word_size, mode, spi_clk, spi_cs_n, spi_mosi, rd_pop, clear_ov,
    input  rd_data, rx_empty, rx_full, rx_level, rx_ov, frame_err
  );

  modport slave (
    input  enable, word_size, mode, spi_clk, spi_cs_n, spi_mosi, rd_pop, clear_ov,
    output rd_data, rx_empty, rx_full, rx_level, rx_ov, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : Oversampled SPI peripheral receiver, MSB-first 1..32 bit words
//               into a first-word-fall-through RX FIFO with sticky status.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  spi_slave_rx_if.slave bus
);

  localparam int                c_addr_w  = $clog2(FIFO_DEPTH);
  localparam logic [c_addr_w:0] c_ptr_one = 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers and sample-edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_rise;
  logic w_fall;
  logic w_sample;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk_s & ~r_sclk_prev;
  assign w_fall   = ~w_sclk_s & r_sclk_prev;
  // Modes 1 and 2 (CPOL^CPHA) sample on the falling edge, modes 0 and 3 on the rising edge
  assign w_sample = (bus.mode[1] ^ bus.mode[0]) ? w_fall : w_rise;

  // --------------------------------------------------------------------------
  // Deserialiser FSM
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [4:0]  r_word_size;
  logic [4:0]  r_bit_cnt;
  logic [31:0] r_shift;
  logic        r_push;
  logic [31:0] r_push_data;
  logic        r_frame_err;

  logic [31:0] w_shift_next;
  logic [31:0] w_mask;

  assign w_shift_next = {r_shift[30:0], w_mosi_s};
  assign w_mask       = 32'hFFFF_FFFF >> (5'd31 - r_word_size);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_word_size <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (bus.clear_ov) begin
        r_frame_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_cs_s && bus.enable) begin
            r_state     <= S_ACTIVE;
            r_word_size <= bus.word_size;
            r_bit_cnt   <= bus.word_size;
            r_shift     <= '0;
          end
        end
        S_ACTIVE: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
          end else if (w_cs_s) begin
            r_state <= S_IDLE;
            // A set here overrides a same-cycle clear_ov above
            if (r_bit_cnt != r_word_size) begin
              r_frame_err <= 1'b1;
            end
          end else if (w_sample) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == 5'd0) begin
              r_push      <= 1'b1;
              r_push_data <= w_shift_next & w_mask;
              r_bit_cnt   <= r_word_size;
            end else begin
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO with extra pointer MSB for full/empty disambiguation
  // --------------------------------------------------------------------------
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [c_addr_w:0] r_wr_ptr;
  logic [c_addr_w:0] r_rd_ptr;
  logic              r_rx_ov;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_overflow;
  logic [c_addr_w:0] w_level;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                      (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
  assign w_pop      = bus.rd_pop && !w_empty;
  assign w_push     = r_push && (!w_full || bus.rd_pop);
  assign w_overflow = r_push && w_full && !bus.rd_pop;
  assign w_level    = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= r_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rx_ov  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_overflow) begin
        r_rx_ov <= 1'b1;
      end else if (bus.clear_ov) begin
        r_rx_ov <= 1'b0;
      end
    end
  end

  // Empty FIFO presents zero so the head never shows stale RAM contents
  assign bus.rd_data   = w_empty ? 32'd0 : r_mem[r_rd_ptr[c_addr_w-1:0]];
  assign bus.rx_empty  = w_empty;
  assign bus.rx_full   = w_full;
  assign bus.rx_level  = 7'(w_level);
  assign bus.rx_ov     = r_rx_ov;
  assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_rx
// Description : Self-checking bench for spi_slave_rx, directed and random frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;

  localparam int c_depth = 16;
  localparam int c_half  = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  int unsigned model_q[$];
  logic        model_ov;

  spi_slave_rx_if bus ();

  spi_slave_rx #(.FIFO_DEPTH(c_depth), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic half_bit();
    repeat (c_half) @(negedge clk);
  endtask

  task automatic frame_start(input logic [1:0] m);
    bus.mode     = m;
    bus.spi_clk  = m[1];
    bus.spi_cs_n = 1'b1;
    repeat (2 * c_half) @(negedge clk);
    bus.spi_cs_n = 1'b0;
    half_bit();
  endtask

  task automatic frame_end();
    bus.spi_cs_n = 1'b1;
    repeat (2 * c_half) @(negedge clk);
  endtask

  // Drives nbits of data MSB-first starting at bit msb; optional pop on the last push cycle
  task automatic send_bits(input logic [1:0] m, input logic [31:0] data, input int msb,
                           input int nbits, input bit pop_last);
    for (int i = msb; i > msb - nbits; i--) begin
      if (!m[0]) begin
        bus.spi_mosi = data[i];
        half_bit();
        bus.spi_clk = ~m[1];
        if (pop_last && i == msb - nbits + 1) begin
          repeat (3) @(negedge clk);
          bus.rd_pop = 1'b1;
          @(negedge clk);
          bus.rd_pop = 1'b0;
          repeat (c_half - 4) @(negedge clk);
        end else begin
          half_bit();
        end
        bus.spi_clk = m[1];
      end else begin
        bus.spi_clk  = ~m[1];
        bus.spi_mosi = data[i];
        half_bit();
        bus.spi_clk = m[1];
        half_bit();
      end
    end
  endtask

  task automatic do_pop();
    bus.rd_pop = 1'b1;
    @(negedge clk);
    bus.rd_pop = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear_ov = 1'b1;
    @(negedge clk);
    bus.clear_ov = 1'b0;
  endtask

  function automatic void model_word(input logic [31:0] w, input int ws);
    logic [31:0] mask;
    mask = (ws == 31) ? 32'hFFFF_FFFF : ((32'd1 << (ws + 1)) - 32'd1);
    if (model_q.size() >= c_depth) model_ov = 1'b1;
    else model_q.push_back(w & mask);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    n_tests++; if (bus.rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.rx_empty); end
    n_tests++; if (bus.rx_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.rx_full); end
    n_tests++; if (bus.rx_level !== 7'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.rx_level); end
    n_tests++; if (bus.rx_ov !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", bus.rx_ov); end
    n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
  endtask

  task automatic test_single();
    bus.word_size = 5'd7;
    frame_start(2'd0);
    send_bits(2'd0, 32'hA5, 7, 8, 1'b0);
    frame_end();
    n_tests++; if (bus.rx_level !== 7'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", bus.rx_level); end
    n_tests++; if (bus.rd_data !== 32'h0000_00A5) begin n_fail++; $display("FAIL single_data: got %h want 000000a5", bus.rd_data); end
    do_pop();
    n_tests++; if (bus.rx_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", bus.rx_empty); end
  endtask

  task automatic test_word32();
    logic [1:0] modes [2];
    modes[0] = 2'd3;
    modes[1] = 2'd1;
    bus.word_size = 5'd31;
    for (int k = 0; k < 2; k++) begin
      frame_start(modes[k]);
      send_bits(modes[k], 32'hDEAD_BEEF, 31, 32, 1'b0);
      frame_end();
      n_tests++; if (bus.rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word32_mode%0d: got %h want deadbeef", modes[k], bus.rd_data); end
      n_tests++; if (bus.rx_level !== 7'd1) begin n_fail++; $display("FAIL word32_level_mode%0d: got %0d want 1", modes[k], bus.rx_level); end
      do_pop();
    end
  endtask

  task automatic test_latency_1bit();
    bus.word_size = 5'd0;
    frame_start(2'd0);
    bus.spi_mosi = 1'b1;
    half_bit();
    bus.spi_clk = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++; if (bus.rx_level !== 7'd1) begin n_fail++; $display("FAIL latency_level: got %0d want 1", bus.rx_level); end
    n_tests++; if (bus.rd_data !== 32'd1) begin n_fail++; $display("FAIL latency_data: got %h want 1", bus.rd_data); end
    repeat (c_half - 4) @(negedge clk);
    bus.spi_clk = 1'b0;
    send_bits(2'd0, 32'd0, 0, 1, 1'b0);
    frame_end();
    n_tests++; if (bus.rx_level !== 7'd2) begin n_fail++; $display("FAIL bit1_level: got %0d want 2", bus.rx_level); end
    do_pop();
    n_tests++; if (bus.rd_data !== 32'd0 || bus.rx_empty !== 1'b0) begin n_fail++; $display("FAIL bit1_second: got %h empty %b want 0 empty 0", bus.rd_data, bus.rx_empty); end
    do_pop();
  endtask

  task automatic test_overflow();
    bus.word_size = 5'd7;
    frame_start(2'd0);
    for (int b = 0; b < 17; b++) send_bits(2'd0, 32'(b), 7, 8, 1'b0);
    frame_end();
    n_tests++; if (bus.rx_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", bus.rx_full); end
    n_tests++; if (bus.rx_ov !== 1'b1) begin n_fail++; $display("FAIL ovf_ov: got %b want 1", bus.rx_ov); end
    n_tests++; if (bus.rx_level !== 7'd16) begin n_fail++; $display("FAIL ovf_level: got %0d want 16", bus.rx_level); end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (bus.rd_data !== 32'(i)) begin n_fail++; $display("FAIL ovf_pop%0d: got %h want %h", i, bus.rd_data, i); end
      do_pop();
    end
    n_tests++; if (bus.rx_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got %b want 1", bus.rx_empty); end
    do_pop();
    n_tests++; if (bus.rx_level !== 7'd0 || bus.rx_ov !== 1'b1) begin n_fail++; $display("FAIL ovf_empty_pop: level %0d ov %b want 0 1", bus.rx_level, bus.rx_ov); end
    do_clear();
    n_tests++; if (bus.rx_ov !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", bus.rx_ov); end
  endtask

  task automatic test_frame_err();
    bus.word_size = 5'd7;
    frame_start(2'd0);
    send_bits(2'd0, 32'h3C, 7, 5, 1'b0);
    frame_end();
    n_tests++; if (bus.rx_empty !== 1'b1) begin n_fail++; $display("FAIL ferr_empty: got %b want 1", bus.rx_empty); end
    n_tests++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b want 1", bus.frame_err); end
    frame_start(2'd0);
    send_bits(2'd0, 32'h3C, 7, 8, 1'b0);
    frame_end();
    n_tests++; if (bus.rd_data !== 32'h3C || bus.rx_level !== 7'd1) begin n_fail++; $display("FAIL ferr_next: got %h level %0d want 3c level 1", bus.rd_data, bus.rx_level); end
    n_tests++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b want 1", bus.frame_err); end
    do_pop();
    do_clear();
    n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", bus.frame_err); end
  endtask

  task automatic test_push_pop_full();
    bus.word_size = 5'd7;
    frame_start(2'd0);
    for (int b = 0; b < 16; b++) send_bits(2'd0, 32'h20 + 32'(b), 7, 8, 1'b0);
    send_bits(2'd0, 32'h30, 7, 8, 1'b1);
    frame_end();
    n_tests++; if (bus.rx_ov !== 1'b0) begin n_fail++; $display("FAIL pp_ov: got %b want 0", bus.rx_ov); end
    n_tests++; if (bus.rx_level !== 7'd16 || bus.rx_full !== 1'b1) begin n_fail++; $display("FAIL pp_level: got %0d full %b want 16 full 1", bus.rx_level, bus.rx_full); end
    for (int i = 1; i <= 16; i++) begin
      n_tests++; if (bus.rd_data !== 32'h20 + 32'(i)) begin n_fail++; $display("FAIL pp_pop%0d: got %h want %h", i, bus.rd_data, 32'h20 + 32'(i)); end
      do_pop();
    end
    n_tests++; if (bus.rx_empty !== 1'b1) begin n_fail++; $display("FAIL pp_drained: got %b want 1", bus.rx_empty); end
  endtask

  task automatic test_enable_drop();
    bus.word_size = 5'd7;
    frame_start(2'd0);
    send_bits(2'd0, 32'h11, 7, 8, 1'b0);
    send_bits(2'd0, 32'hFF, 7, 4, 1'b0);
    bus.enable = 1'b0;
    repeat (4) @(negedge clk);
    frame_end();
    bus.enable = 1'b1;
    n_tests++; if (bus.rx_level !== 7'd1 || bus.rd_data !== 32'h11) begin n_fail++; $display("FAIL en_keep: got %h level %0d want 11 level 1", bus.rd_data, bus.rx_level); end
    n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL en_no_ferr: got %b want 0", bus.frame_err); end
    frame_start(2'd0);
    send_bits(2'd0, 32'h5A, 7, 8, 1'b0);
    frame_end();
    do_pop();
    n_tests++; if (bus.rd_data !== 32'h5A || bus.rx_level !== 7'd1) begin n_fail++; $display("FAIL en_next: got %h level %0d want 5a level 1", bus.rd_data, bus.rx_level); end
    do_pop();
  endtask

  task automatic test_reset_midword();
    bus.word_size = 5'd7;
    frame_start(2'd0);
    send_bits(2'd0, 32'h55, 7, 8, 1'b0);
    send_bits(2'd0, 32'hFF, 7, 3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.rx_level !== 7'd0 || bus.rx_empty !== 1'b1 || bus.rx_full !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fifo: level %0d empty %b full %b want 0 1 0", bus.rx_level, bus.rx_empty, bus.rx_full); end
    n_tests++; if (bus.rd_data !== 32'd0 || bus.rx_ov !== 1'b0 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out: data %h ov %b ferr %b want 0 0 0", bus.rd_data, bus.rx_ov, bus.frame_err); end
    reset = 1'b0;
    frame_end();
    frame_start(2'd0);
    send_bits(2'd0, 32'h81, 7, 8, 1'b0);
    frame_end();
    n_tests++; if (bus.rd_data !== 32'h81 || bus.rx_level !== 7'd1) begin n_fail++; $display("FAIL rst_mid_next: got %h level %0d want 81 level 1", bus.rd_data, bus.rx_level); end
    n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ferr: got %b want 0", bus.frame_err); end
    do_pop();
  endtask

  task automatic test_random();
    logic [1:0]  m;
    int          ws;
    int          nw;
    int          np;
    logic [31:0] d;
    int unsigned exp;
    model_q.delete();
    model_ov = 1'b0;
    for (int f = 0; f < 10; f++) begin
      m  = 2'($urandom_range(0, 3));
      ws = $urandom_range(0, 31);
      nw = $urandom_range(1, 3);
      bus.word_size = 5'(ws);
      frame_start(m);
      for (int w = 0; w < nw; w++) begin
        d = $urandom;
        send_bits(m, d, ws, ws + 1, 1'b0);
        model_word(d, ws);
        // Mid-frame word_size change must not affect the current frame
        if (w == 0) bus.word_size = 5'($urandom_range(0, 31));
      end
      frame_end();
      exp = (model_q.size() > 0) ? model_q[0] : 0;
      n_tests++; if (bus.rx_level !== 7'(model_q.size())) begin n_fail++; $display("FAIL rnd%0d_level: got %0d want %0d", f, bus.rx_level, model_q.size()); end
      n_tests++; if (bus.rd_data !== exp) begin n_fail++; $display("FAIL rnd%0d_head: got %h want %h", f, bus.rd_data, exp); end
      n_tests++; if (bus.rx_empty !== (model_q.size() == 0) || bus.rx_full !== (model_q.size() == c_depth)) begin n_fail++; $display("FAIL rnd%0d_flags: empty %b full %b size %0d", f, bus.rx_empty, bus.rx_full, model_q.size()); end
      n_tests++; if (bus.rx_ov !== model_ov || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_status: ov %b ferr %b want %b 0", f, bus.rx_ov, bus.frame_err, model_ov); end
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        if (model_q.size() > 0) begin
          exp = model_q.pop_front();
          n_tests++; if (bus.rd_data !== exp) begin n_fail++; $display("FAIL rnd%0d_pop: got %h want %h", f, bus.rd_data, exp); end
        end
        do_pop();
      end
    end
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      n_tests++; if (bus.rd_data !== exp) begin n_fail++; $display("FAIL rnd_drain: got %h want %h", bus.rd_data, exp); end
      do_pop();
    end
    n_tests++; if (bus.rx_empty !== 1'b1 || bus.rx_level !== 7'd0) begin n_fail++; $display("FAIL rnd_final: empty %b level %0d want 1 0", bus.rx_empty, bus.rx_level); end
  endtask

  initial begin
    reset         = 1'b1;
    bus.enable    = 1'b1;
    bus.word_size = 5'd7;
    bus.mode      = 2'd0;
    bus.spi_clk   = 1'b0;
    bus.spi_cs_n  = 1'b1;
    bus.spi_mosi  = 1'b0;
    bus.rd_pop    = 1'b0;
    bus.clear_ov  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_word32();
    test_latency_1bit();
    test_overflow();
    test_frame_err();
    test_push_pop_full();
    test_enable_drop();
    test_reset_midword();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
